// File: rtl/enc_pkg.sv
// Shared definitions for the convolutional-encoder frame sequencer:
// rate codes, tail length, FSM states and the rate-to-puncture-period map.
package enc_pkg;

    localparam logic [1:0] RATE_1_2 = 2'd0;
    localparam logic [1:0] RATE_2_3 = 2'd1;
    localparam logic [1:0] RATE_3_4 = 2'd2;

    localparam int TAIL_BITS = 6;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        DATA,
        TAIL,
        PAD,
        FLUSH,
        DONE
    } enc_state_t;

    // Cycles per puncturing period: P-1 input bits plus one non-slot cycle.
    function automatic logic [2:0] rate_period(input logic [1:0] rate);
        case (rate)
            RATE_2_3: rate_period = 3'd3;
            RATE_3_4: rate_period = 3'd4;
            default:  rate_period = 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/punct_cadence.sv
// Puncturing phase counter: phases 0..P-2 are input-bit slots, phase P-1
// is the cycle where the encoder emits without consuming a bit.
module punct_cadence (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       adv,
    input  logic [2:0] period,
    output logic       slot,
    output logic       period_end
);

    logic [2:0] phase_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg <= '0;
        end else if (clr) begin
            phase_reg <= '0;
        end else if (adv) begin
            phase_reg <= period_end ? 3'd0 : phase_reg + 3'd1;
        end
    end

    assign period_end = (phase_reg == period - 3'd1);
    assign slot       = !period_end;

endmodule

// File: rtl/encoder_ctrl.sv
// Frame sequencer feeding the serial 802.11a convolutional encoder: data,
// 6 tail zeros, zero pad to a whole OFDM symbol, then an encoder flush.
module encoder_ctrl
    import enc_pkg::*;
#(
    parameter int ENC_LAT = 2,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cfg_rate,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [7:0]       cfg_ndbps,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    output logic             enc_clr,
    output logic             enc_en,
    output logic             enc_take,
    output logic             enc_data,
    output logic [1:0]       enc_rate,
    output logic             busy,
    output logic             done,
    output logic [7:0]       sym_cnt,
    output logic             err
);

    enc_state_t       state_reg, state_next;
    logic [1:0]       rate_reg;
    logic [LEN_W-1:0] len_reg;
    logic [7:0]       ndbps_reg;
    logic [LEN_W-1:0] bit_cnt_reg;
    logic [2:0]       tail_cnt_reg;
    logic [7:0]       sym_bit_reg;
    logic [7:0]       sym_cnt_reg;
    logic [7:0]       flush_cnt_reg;
    logic             en_reg, take_reg, data_reg, err_reg;

    logic cfg_bad, start_ok, active, slot, period_end, stall, adv, take;

    assign cfg_bad  = (cfg_rate == 2'd3) || (cfg_ndbps == 8'd0);
    assign start_ok = (state_reg == IDLE) && start && !cfg_bad;
    assign active   = (state_reg == DATA) || (state_reg == TAIL) || (state_reg == PAD);
    // Only a DATA slot can wait on upstream; tail, pad and non-slot cycles always advance.
    assign stall    = (state_reg == DATA) && slot && !in_valid;
    assign adv      = (active && !stall) || (state_reg == FLUSH);
    assign take     = active && slot && !stall;

    punct_cadence u_cadence (
        .clk        (clk),
        .reset      (reset),
        .clr        (state_reg == CLR),
        .adv        (adv && active),
        .period     (rate_period(rate_reg)),
        .slot       (slot),
        .period_end (period_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (start_ok) state_next = CLR;
            CLR:   state_next = (len_reg == '0) ? TAIL : DATA;
            DATA:  if (take && (bit_cnt_reg == len_reg - LEN_W'(1))) state_next = TAIL;
            TAIL:  if (take && (tail_cnt_reg == 3'(TAIL_BITS - 1))) state_next = PAD;
            // Slot streams always end on a period's last slot, so the symbol
            // boundary is confirmed on the following non-slot cycle.
            PAD:   if (period_end && (sym_bit_reg == 8'd0)) state_next = FLUSH;
            FLUSH: if (flush_cnt_reg == 8'(ENC_LAT - 1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == DATA) && slot;
        enc_clr  = (state_reg == CLR);
        busy     = (state_reg != IDLE) && (state_reg != DONE);
        done     = (state_reg == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_reg      <= '0;
            len_reg       <= '0;
            ndbps_reg     <= '0;
            bit_cnt_reg   <= '0;
            tail_cnt_reg  <= '0;
            sym_bit_reg   <= '0;
            sym_cnt_reg   <= '0;
            flush_cnt_reg <= '0;
            en_reg        <= 1'b0;
            take_reg      <= 1'b0;
            data_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            en_reg   <= adv;
            take_reg <= take;
            data_reg <= take && (state_reg == DATA) && in_data;
            err_reg  <= (state_reg == IDLE) && start && cfg_bad;
            if (start_ok) begin
                rate_reg      <= cfg_rate;
                len_reg       <= cfg_len;
                ndbps_reg     <= cfg_ndbps;
                bit_cnt_reg   <= '0;
                tail_cnt_reg  <= '0;
                sym_bit_reg   <= '0;
                sym_cnt_reg   <= '0;
                flush_cnt_reg <= '0;
            end else begin
                if (take && (state_reg == DATA)) bit_cnt_reg <= bit_cnt_reg + LEN_W'(1);
                if (take && (state_reg == TAIL)) tail_cnt_reg <= tail_cnt_reg + 3'd1;
                if (take) begin
                    if (sym_bit_reg == ndbps_reg - 8'd1) begin
                        sym_bit_reg <= 8'd0;
                        sym_cnt_reg <= sym_cnt_reg + 8'd1;
                    end else begin
                        sym_bit_reg <= sym_bit_reg + 8'd1;
                    end
                end
                if (state_reg == FLUSH) flush_cnt_reg <= flush_cnt_reg + 8'd1;
            end
        end
    end

    assign enc_en   = en_reg;
    assign enc_take = take_reg;
    assign enc_data = data_reg;
    assign enc_rate = rate_reg;
    assign sym_cnt  = sym_cnt_reg;
    assign err      = err_reg;

endmodule
